// File: rtl/shift_wb_pkg.sv
// rtl/shift_wb_pkg.sv - shared entry and flag types for the shifter writeback stage
package shift_wb_pkg;

   localparam int DATA_W = 32;
   localparam int RD_W   = 5;
   localparam int FLAG_W = 4;

   typedef struct packed {
      logic n;
      logic z;
      logic c;
      logic v;
   } flags_t;

   typedef struct packed {
      logic [DATA_W-1:0] result;
      flags_t            flags;
      logic [RD_W-1:0]   rd;
   } entry_t;

endpackage

// File: rtl/shift_wb_fifo.sv
// rtl/shift_wb_fifo.sv - DEPTH-entry entry_t FIFO with wrapping pointers and occupancy count
// Callers must gate i_push with !o_full and i_pop with !o_empty.
module shift_wb_fifo
   import shift_wb_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   i_push,
   input  entry_t                 i_data,
   input  logic                   i_pop,
   output entry_t                 o_head,
   output logic                   o_full,
   output logic                   o_empty,
   output logic [$clog2(DEPTH):0] o_count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W-1:0] PTR_ONE  = 1;
   localparam logic [PTR_W:0]   CNT_ONE  = 1;
   localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);

   entry_t           r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W:0]   r_count;

   // Storage is cleared too so the head reads as zero straight out of reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (i_push) begin
            r_mem[r_wr_ptr] <= i_data;
            r_wr_ptr        <= r_wr_ptr + PTR_ONE;
         end
         if (i_pop) r_rd_ptr <= r_rd_ptr + PTR_ONE;
         case ({i_push, i_pop})
            2'b10:   r_count <= r_count + CNT_ONE;
            2'b01:   r_count <= r_count - CNT_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_head  = r_mem[r_rd_ptr];
   assign o_full  = (r_count == CNT_FULL);
   assign o_empty = (r_count == '0);
   assign o_count = r_count;

endmodule

// File: rtl/shift_wb_stage.sv
// rtl/shift_wb_stage.sv - registered shifter writeback stage with sticky flags and flag check
// Optional SHIFT_WB_ZERO_DROP_EN: accepted entries with rd == 0 are handshaken but not stored.
module shift_wb_stage #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 2,
   parameter int RD_W   = 5
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               in_valid,
   output logic                               in_ready,
   input  logic [DATA_W-1:0]                  in_result,
   input  logic                               in_zero,
   input  logic                               in_carry,
   input  logic                               in_negative,
   input  logic                               in_overflow,
   input  logic [RD_W-1:0]                    in_rd,
   output logic                               out_valid,
   input  logic                               out_ready,
   output logic [DATA_W-1:0]                  out_result,
   output logic [shift_wb_pkg::FLAG_W-1:0]    out_flags,
   output logic [RD_W-1:0]                    out_rd,
   output logic [$clog2(DEPTH):0]             count,
   output logic [shift_wb_pkg::FLAG_W-1:0]    sticky_flags,
   input  logic                               sticky_clr,
   output logic                               flag_err
);
   import shift_wb_pkg::*;

   entry_t              w_in_entry;
   entry_t              w_head;
   logic                w_full;
   logic                w_empty;
   logic                w_push;
   logic                w_store;
   logic                w_pop;
   logic                w_bad;
   logic [FLAG_W-1:0]   r_sticky;
   logic                r_flag_err;

   assign w_in_entry = {in_result, in_negative, in_zero, in_carry, in_overflow, in_rd};

   assign in_ready  = !w_full;
   assign out_valid = !w_empty;
   assign w_push    = in_valid && in_ready;
   assign w_pop     = out_valid && out_ready;

`ifdef SHIFT_WB_ZERO_DROP_EN
   assign w_store = w_push && (in_rd != '0);
`else
   assign w_store = w_push;
`endif

   // The shifter never overflows; carry is not derivable from the result, so it is not checked.
   assign w_bad = (in_zero != (in_result == '0)) ||
                  (in_negative != in_result[DATA_W-1]) ||
                  in_overflow;

   shift_wb_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_store),
      .i_data  (w_in_entry),
      .i_pop   (w_pop),
      .o_head  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (count)
   );

   assign out_result = w_head.result;
   assign out_flags  = w_head.flags;
   assign out_rd     = w_head.rd;

   // A clear coinciding with a pop keeps only the popped flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sticky <= '0;
      end else if (w_pop) begin
         r_sticky <= (sticky_clr ? '0 : r_sticky) | w_head.flags;
      end else if (sticky_clr) begin
         r_sticky <= '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_flag_err <= 1'b0;
      end else if (w_push && w_bad) begin
         r_flag_err <= 1'b1;
      end
   end

   assign sticky_flags = r_sticky;
   assign flag_err     = r_flag_err;

endmodule

// File: tb/tb_shift_wb_stage.sv
// tb/tb_shift_wb_stage.sv - scoreboard bench for shift_wb_stage (honours SHIFT_WB_ZERO_DROP_EN)
module tb_shift_wb_stage;

   localparam int DATA_W = 32;
   localparam int DEPTH  = 2;
   localparam int RD_W   = 5;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_result;
   logic              in_zero;
   logic              in_carry;
   logic              in_negative;
   logic              in_overflow;
   logic [RD_W-1:0]   in_rd;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_result;
   logic [3:0]        out_flags;
   logic [RD_W-1:0]   out_rd;
   logic [1:0]        count;
   logic [3:0]        sticky_flags;
   logic              sticky_clr;
   logic              flag_err;

   typedef struct packed {
      logic [31:0] res;
      logic [3:0]  fl;
      logic [4:0]  rd;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   n_checks = 0;
   int   n_fail   = 0;

   shift_wb_stage #(.DATA_W(DATA_W), .DEPTH(DEPTH), .RD_W(RD_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_result    (in_result),
      .in_zero      (in_zero),
      .in_carry     (in_carry),
      .in_negative  (in_negative),
      .in_overflow  (in_overflow),
      .in_rd        (in_rd),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_result   (out_result),
      .out_flags    (out_flags),
      .out_rd       (out_rd),
      .count        (count),
      .sticky_flags (sticky_flags),
      .sticky_clr   (sticky_clr),
      .flag_err     (flag_err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drives a shifter-consistent input entry: Z and N follow the result, V is 0.
   task automatic set_in(input logic v, input logic [31:0] r, input logic c, input logic [4:0] rd);
      in_valid    = v;
      in_result   = r;
      in_zero     = (r == 32'd0);
      in_negative = r[31];
      in_carry    = c;
      in_overflow = 1'b0;
      in_rd       = rd;
   endtask

   function automatic exp_t exp_of();
      return {in_result, in_negative, in_zero, in_carry, in_overflow, in_rd};
   endfunction

   task automatic test_reset();
      rst = 1'b1; out_ready = 1'b0; sticky_clr = 1'b0;
      set_in(1'b0, 32'd0, 1'b0, 5'd1);
      #3;
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
      n_checks++; if (count !== 2'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", count); end
      n_checks++; if ({out_result, out_flags, out_rd} !== 41'd0) begin n_fail++; $display("FAIL reset_out_fields got %h exp 0", {out_result, out_flags, out_rd}); end
      n_checks++; if (sticky_flags !== 4'd0) begin n_fail++; $display("FAIL reset_sticky got %b exp 0000", sticky_flags); end
      n_checks++; if (flag_err !== 1'b0) begin n_fail++; $display("FAIL reset_flag_err got %b exp 0", flag_err); end
      tick();
      rst = 1'b0;
      tick(); tick();
      n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || count !== 2'd0) begin n_fail++; $display("FAIL idle_state got rdy=%b vld=%b cnt=%0d exp 1 0 0", in_ready, out_valid, count); end
   endtask

   task automatic test_hold();
      out_ready = 1'b0;
      set_in(1'b1, 32'h8000_0000, 1'b1, 5'd3);
      sb.push_back(exp_of());
      tick();
      in_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL hold_valid cyc %0d got %b exp 1", k, out_valid); end
         n_checks++; if ({out_result, out_flags, out_rd} !== {32'h8000_0000, 4'b1010, 5'd3}) begin n_fail++; $display("FAIL hold_fields cyc %0d got %h/%b/%0d exp 80000000/1010/3", k, out_result, out_flags, out_rd); end
         tick();
      end
      out_ready = 1'b1;
      e = sb.pop_front();
      n_checks++; if ({out_result, out_flags, out_rd} !== e) begin n_fail++; $display("FAIL hold_pop got %h exp %h", {out_result, out_flags, out_rd}, e); end
      tick();
      out_ready = 1'b0;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL hold_drained got %b exp 0", out_valid); end
   endtask

   task automatic test_full();
      int popped;
      logic pushed;
      out_ready = 1'b0;
      set_in(1'b1, 32'h0000_1111, 1'b0, 5'd1); sb.push_back(exp_of()); tick();
      set_in(1'b1, 32'hF000_2222, 1'b1, 5'd2); sb.push_back(exp_of()); tick();
      in_valid = 1'b0;
      n_checks++; if (count !== 2'd2) begin n_fail++; $display("FAIL full_count got %0d exp 2", count); end
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_in_ready got %b exp 0", in_ready); end
      set_in(1'b1, 32'h0000_3333, 1'b0, 5'd4);
      out_ready = 1'b1;
      popped = 0; pushed = 1'b0;
      for (int cyc = 0; cyc < 20 && (sb.size() != 0 || !pushed); cyc++) begin
         n_checks++; if (count > 2'd2) begin n_fail++; $display("FAIL full_count_bound got %0d exp <=2", count); end
         if (out_valid) begin
            popped++;
            n_checks++;
            if (sb.size() == 0) begin n_fail++; $display("FAIL full_extra_pop got %h exp none", {out_result, out_flags, out_rd}); end
            else begin
               e = sb.pop_front();
               if ({out_result, out_flags, out_rd} !== e) begin n_fail++; $display("FAIL full_order got %h exp %h", {out_result, out_flags, out_rd}, e); end
            end
         end
         if (in_valid && in_ready) begin sb.push_back(exp_of()); pushed = 1'b1; end
         tick();
         if (pushed) in_valid = 1'b0;
      end
      n_checks++; if (popped !== 3 || sb.size() != 0) begin n_fail++; $display("FAIL full_delivered got %0d exp 3", popped); end
      out_ready = 1'b0;
      sb.delete();
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b1;
      set_in(1'b1, 32'h0000_0001, 1'b0, 5'd5); sb.push_back(exp_of());
      tick();
      for (int i = 0; i < 8; i++) begin
         set_in(1'b1, $urandom(), 1'($urandom_range(0, 1)), 5'($urandom_range(1, 31)));
         n_checks++; if (count !== 2'd1) begin n_fail++; $display("FAIL b2b_count cyc %0d got %0d exp 1", i, count); end
         n_checks++;
         if (!out_valid || sb.size() == 0) begin n_fail++; $display("FAIL b2b_valid cyc %0d got %b exp 1", i, out_valid); end
         else begin
            e = sb.pop_front();
            if ({out_result, out_flags, out_rd} !== e) begin n_fail++; $display("FAIL b2b_order cyc %0d got %h exp %h", i, {out_result, out_flags, out_rd}, e); end
         end
         if (in_valid && in_ready) sb.push_back(exp_of());
         tick();
      end
      in_valid = 1'b0;
      n_checks++;
      if (!out_valid || sb.size() != 1) begin n_fail++; $display("FAIL b2b_last got %b exp 1", out_valid); end
      else begin
         e = sb.pop_front();
         if ({out_result, out_flags, out_rd} !== e) begin n_fail++; $display("FAIL b2b_last_data got %h exp %h", {out_result, out_flags, out_rd}, e); end
      end
      tick();
      out_ready = 1'b0;
      n_checks++; if (count !== 2'd0) begin n_fail++; $display("FAIL b2b_drain got %0d exp 0", count); end
      sb.delete();
   endtask

   task automatic test_sticky();
      out_ready = 1'b0; in_valid = 1'b0;
      sticky_clr = 1'b1; tick(); sticky_clr = 1'b0;
      n_checks++; if (sticky_flags !== 4'b0000) begin n_fail++; $display("FAIL sticky_init got %b exp 0000", sticky_flags); end
      set_in(1'b1, 32'd0, 1'b0, 5'd6); sb.push_back(exp_of());
      tick();
      set_in(1'b1, 32'd5, 1'b1, 5'd7);
      out_ready = 1'b1;
      e = sb.pop_front();
      n_checks++; if ({out_result, out_flags, out_rd} !== e) begin n_fail++; $display("FAIL sticky_pop1 got %h exp %h", {out_result, out_flags, out_rd}, e); end
      sb.push_back(exp_of());
      tick();
      in_valid = 1'b0;
      n_checks++; if (sticky_flags !== 4'b0100) begin n_fail++; $display("FAIL sticky_first got %b exp 0100", sticky_flags); end
      sticky_clr = 1'b1;
      e = sb.pop_front();
      n_checks++; if ({out_result, out_flags, out_rd} !== e) begin n_fail++; $display("FAIL sticky_pop2 got %h exp %h", {out_result, out_flags, out_rd}, e); end
      tick();
      sticky_clr = 1'b0; out_ready = 1'b0;
      n_checks++; if (sticky_flags !== 4'b0010) begin n_fail++; $display("FAIL sticky_clr_pop got %b exp 0010", sticky_flags); end
      sticky_clr = 1'b1; tick(); sticky_clr = 1'b0;
      n_checks++; if (sticky_flags !== 4'b0000) begin n_fail++; $display("FAIL sticky_clr_only got %b exp 0000", sticky_flags); end
      n_checks++; if (flag_err !== 1'b0) begin n_fail++; $display("FAIL err_clean got %b exp 0", flag_err); end
   endtask

   task automatic test_flag_err();
      for (int c = 0; c < 3; c++) begin
         out_ready = 1'b0;
         set_in(1'b1, (c == 1) ? 32'h8000_0000 : ((c == 0) ? 32'd0 : 32'd1), 1'b0, 5'd9);
         if (c == 0) in_zero = 1'b0;
         if (c == 1) in_negative = 1'b0;
         if (c == 2) in_overflow = 1'b1;
         n_checks++; if (flag_err !== 1'b0) begin n_fail++; $display("FAIL err_pre case %0d got %b exp 0", c, flag_err); end
         sb.push_back(exp_of());
         tick();
         in_valid = 1'b0;
         n_checks++; if (flag_err !== 1'b1) begin n_fail++; $display("FAIL err_set case %0d got %b exp 1", c, flag_err); end
         out_ready = 1'b1;
         e = sb.pop_front();
         n_checks++; if (!out_valid || {out_result, out_flags, out_rd} !== e) begin n_fail++; $display("FAIL err_entry case %0d got %h exp %h", c, {out_result, out_flags, out_rd}, e); end
         tick();
         out_ready = 1'b0; sticky_clr = 1'b1; tick(); sticky_clr = 1'b0; tick();
         n_checks++; if (flag_err !== 1'b1) begin n_fail++; $display("FAIL err_sticky case %0d got %b exp 1", c, flag_err); end
         rst = 1'b1; #2; rst = 1'b0;
         tick();
         n_checks++; if (flag_err !== 1'b0) begin n_fail++; $display("FAIL err_rst case %0d got %b exp 0", c, flag_err); end
      end
   endtask

   task automatic test_rd0();
      out_ready = 1'b0;
      set_in(1'b1, 32'h0000_0042, 1'b0, 5'd0);
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rd0_in_ready got %b exp 1", in_ready); end
      tick();
      in_valid = 1'b0;
`ifdef SHIFT_WB_ZERO_DROP_EN
      n_checks++; if (count !== 2'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL rd0_drop got cnt=%0d vld=%b exp 0 0", count, out_valid); end
      n_checks++; if (flag_err !== 1'b0) begin n_fail++; $display("FAIL rd0_err got %b exp 0", flag_err); end
`else
      n_checks++; if (count !== 2'd1 || out_valid !== 1'b1) begin n_fail++; $display("FAIL rd0_store got cnt=%0d vld=%b exp 1 1", count, out_valid); end
      n_checks++; if ({out_result, out_rd} !== {32'h0000_0042, 5'd0}) begin n_fail++; $display("FAIL rd0_data got %h/%0d exp 42/0", out_result, out_rd); end
      out_ready = 1'b1; tick(); out_ready = 1'b0;
      n_checks++; if (count !== 2'd0) begin n_fail++; $display("FAIL rd0_drain got %0d exp 0", count); end
`endif
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0;
      set_in(1'b1, 32'h1234_5678, 1'b1, 5'd10); tick();
      set_in(1'b1, 32'h9abc_def0, 1'b0, 5'd11); tick();
      in_valid = 1'b0;
      n_checks++; if (count !== 2'd2) begin n_fail++; $display("FAIL mid_prefill got %0d exp 2", count); end
      #2 rst = 1'b1;
      #1;
      n_checks++; if (count !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_async got cnt=%0d vld=%b rdy=%b exp 0 0 1", count, out_valid, in_ready); end
      n_checks++; if ({out_result, out_flags, out_rd} !== 41'd0) begin n_fail++; $display("FAIL mid_fields got %h exp 0", {out_result, out_flags, out_rd}); end
      #1 rst = 1'b0;
      tick();
      n_checks++; if (count !== 2'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_after got cnt=%0d vld=%b exp 0 0", count, out_valid); end
      sb.delete();
   endtask

   initial begin
      test_reset();
      test_hold();
      test_full();
      test_back_to_back();
      test_sticky();
      test_flag_err();
      test_rd0();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
